// File: rtl/vfu_cmd_bridge.sv
// -----------------------------------------------------------------------------
// vfu_cmd_bridge
//
// Bridges the CFU command/response interface to a vector core issue port.
// Every accepted command is forwarded to the vector core and is given one slot
// in an in-order response queue. Scalar-result instructions (vmv.x.s) wait in
// the queue until the core returns their result. All other instructions are
// complete when they are written and answer with zero. Responses leave strictly
// in acceptance order.
//
// Handshake semantics (all three channels):
//   A transfer happens on a rising clk edge where valid & ready are both 1.
//   cmd:  the bridge never waits for cmd_valid before raising cmd_ready.
//         cmd_ready = vec_insn_ready & ~full.
//   vec:  vec_insn_valid = cmd_valid & ~full. It does not look at
//         vec_insn_ready, so the core sees the same transfer as the CFU.
//   rsp:  rsp_valid / rsp_payload_output are registered. While rsp_ready is
//         low they hold their value.
//
// Optional feature: define VFU_TIMEOUT_EN to build a head-of-queue watchdog.
// After TIMEOUT_CYCLES cycles it completes a stalled result entry with
// 32'hDEAD_BEEF and sets the sticky err_timeout.
// Without the macro, err_timeout is tied to 0.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cmd_valid / cmd_ready      CFU command handshake
//   cmd_payload_instruction    instruction (INSN_WIDTH)
//   cmd_payload_inputs_0/1     rs1 / rs2 values (XLEN)
//   rsp_valid / rsp_ready      CFU response handshake
//   rsp_payload_output         response data (XLEN)
//   vec_insn_valid / _ready    vector core issue handshake
//   vec_insn                   forwarded instruction
//   vec_data_in_1 / _2         forwarded rs1 / rs2
//   vec_result_valid           one-cycle strobe per scalar result, in issue order
//   vec_result                 scalar result data
//   err_timeout                sticky watchdog error
// -----------------------------------------------------------------------------
module vfu_cmd_bridge #(
   parameter int INSN_WIDTH     = 32,
   parameter int XLEN           = 32,
   parameter int RSP_DEPTH      = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [INSN_WIDTH-1:0] cmd_payload_instruction,
   input  logic [XLEN-1:0]       cmd_payload_inputs_0,
   input  logic [XLEN-1:0]       cmd_payload_inputs_1,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [XLEN-1:0]       rsp_payload_output,
   output logic                  vec_insn_valid,
   input  logic                  vec_insn_ready,
   output logic [INSN_WIDTH-1:0] vec_insn,
   output logic [XLEN-1:0]       vec_data_in_1,
   output logic [XLEN-1:0]       vec_data_in_2,
   input  logic                  vec_result_valid,
   input  logic [XLEN-1:0]       vec_result,
   output logic                  err_timeout
);

   localparam int              PW      = $clog2(RSP_DEPTH);
   localparam logic [PW:0]     DEPTH_C = (PW+1)'(RSP_DEPTH);
   localparam logic [PW-1:0]   PTR_ONE = PW'(1);
   localparam logic [PW:0]     CNT_ONE = (PW+1)'(1);
   localparam logic [6:0]      OPC_V   = 7'b1010111;
   localparam logic [2:0]      F3_MVX  = 3'b010;
   localparam logic [5:0]      F6_VMV  = 6'b010000;

   // Queue storage: one {needs_result, done, data} triple per slot.
   logic [RSP_DEPTH-1:0] q_needs;
   logic [RSP_DEPTH-1:0] q_done;
   logic [XLEN-1:0]      q_data   [RSP_DEPTH];
   logic [RSP_DEPTH-1:0] q_needs_n;
   logic [RSP_DEPTH-1:0] q_done_n;
   logic [XLEN-1:0]      q_data_n [RSP_DEPTH];

   logic [PW-1:0] head, tail, head_n, tail_n;
   logic [PW:0]   count, count_n;

   logic            rsp_valid_q, rsp_valid_n;
   logic [XLEN-1:0] rsp_data_q, rsp_data_n;

   logic          full, accept, pop, needs_result;
   logic          fill_found, fill_hit;
   logic [PW-1:0] fill_idx, scan_idx;
   logic          to_fire;

   // ---------------------------------------------------------------------------
   // Issue path
   // ---------------------------------------------------------------------------
   assign full           = (count == DEPTH_C);
   assign vec_insn_valid = cmd_valid & ~full;
   assign cmd_ready      = vec_insn_ready & ~full;
   assign accept         = cmd_valid & cmd_ready;
   assign vec_insn       = cmd_payload_instruction;
   assign vec_data_in_1  = cmd_payload_inputs_0;
   assign vec_data_in_2  = cmd_payload_inputs_1;

   // vmv.x.s is the only instruction that returns a scalar to the CPU.
   assign needs_result = (cmd_payload_instruction[6:0]   == OPC_V)  &
                         (cmd_payload_instruction[14:12] == F3_MVX) &
                         (cmd_payload_instruction[31:26] == F6_VMV);

   assign pop = rsp_valid_q & rsp_ready;

   // ---------------------------------------------------------------------------
   // Fill pointer: the oldest occupied slot still waiting for a result.
   // The core answers in issue order, so the next result always belongs to
   // this slot. The scan only covers slots that were occupied before this
   // cycle. A command accepted in the same cycle as a strobe can therefore
   // never receive that strobe.
   // ---------------------------------------------------------------------------
   always_comb begin
      fill_found = 1'b0;
      fill_idx   = '0;
      scan_idx   = '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
         scan_idx = head + PW'(i);
         if (!fill_found && ((PW+1)'(i) < count) &&
             q_needs[scan_idx] && !q_done[scan_idx]) begin
            fill_found = 1'b1;
            fill_idx   = scan_idx;
         end
      end
   end

`ifdef VFU_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [TW-1:0] to_cnt;
   logic [PW:0]   drop_cnt;
   logic          head_pending;
   logic          err_q;

   assign head_pending = (count != '0) & q_needs[head] & ~q_done[head];

   // Each forced completion still owes one late strobe from the core.
   // drop_cnt counts these strobes, and they are discarded so that they do
   // not complete a younger entry.
   assign fill_hit = vec_result_valid & fill_found & (drop_cnt == '0);

   // A real result that arrives in the firing cycle takes priority.
   assign to_fire = head_pending & (to_cnt == TW'(TIMEOUT_CYCLES - 1)) &
                    ~(fill_hit & (fill_idx == head));

   always_ff @(posedge clk) begin
      if (reset) begin
         to_cnt   <= '0;
         drop_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (pop || !head_pending || to_fire)
            to_cnt <= '0;
         else
            to_cnt <= to_cnt + TW'(1);

         if (to_fire && !(vec_result_valid && drop_cnt != '0)) begin
            if (drop_cnt != '1)
               drop_cnt <= drop_cnt + CNT_ONE;
         end else if (!to_fire && vec_result_valid && drop_cnt != '0) begin
            drop_cnt <= drop_cnt - CNT_ONE;
         end

         if (to_fire)
            err_q <= 1'b1;
      end
   end

   assign err_timeout = err_q;
`else
   assign fill_hit    = vec_result_valid & fill_found;
   assign to_fire     = 1'b0;
   assign err_timeout = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Queue next state. The response register is loaded from the head slot as
   // it will be after this edge. This gives a one-cycle response latency for
   // commands that complete when they are written.
   // ---------------------------------------------------------------------------
   always_comb begin
      q_needs_n = q_needs;
      q_done_n  = q_done;
      q_data_n  = q_data;

      if (fill_hit) begin
         q_done_n[fill_idx] = 1'b1;
         q_data_n[fill_idx] = vec_result;
      end

      if (to_fire) begin
         q_done_n[head] = 1'b1;
         q_data_n[head] = XLEN'(32'hDEAD_BEEF);
      end

      // The tail slot is free whenever accept is high (queue not full), so it
      // never collides with the fill or watchdog writes above.
      if (accept) begin
         q_needs_n[tail] = needs_result;
         q_done_n[tail]  = ~needs_result;
         q_data_n[tail]  = '0;
      end

      head_n = pop    ? head + PTR_ONE : head;
      tail_n = accept ? tail + PTR_ONE : tail;

      case ({accept, pop})
         2'b10:   count_n = count + CNT_ONE;
         2'b01:   count_n = count - CNT_ONE;
         default: count_n = count;
      endcase

      rsp_valid_n = (count_n != '0) & q_done_n[head_n];
      rsp_data_n  = rsp_valid_n ? q_data_n[head_n] : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         q_needs     <= '0;
         q_done      <= '0;
         for (int i = 0; i < RSP_DEPTH; i++)
            q_data[i] <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         head        <= head_n;
         tail        <= tail_n;
         count       <= count_n;
         q_needs     <= q_needs_n;
         q_done      <= q_done_n;
         q_data      <= q_data_n;
         rsp_valid_q <= rsp_valid_n;
         rsp_data_q  <= rsp_data_n;
      end
   end

   assign rsp_valid          = rsp_valid_q;
   assign rsp_payload_output = rsp_data_q;

endmodule

// File: tb/tb_vfu_cmd_bridge.sv
// -----------------------------------------------------------------------------
// Testbench for vfu_cmd_bridge (RSP_DEPTH = 4).
// Structure:
//   - a table of handshake and decode vectors,
//   - directed multi-cycle sequences,
//   - a randomized run checked against a queue-level reference model.
// With VFU_TIMEOUT_EN defined, the DUT is built with TIMEOUT_CYCLES = 16 and
// the watchdog sequence is added.
// -----------------------------------------------------------------------------
module tb_vfu_cmd_bridge;

   localparam int XL    = 32;
   localparam int IW    = 32;
   localparam int DEPTH = 4;
`ifdef VFU_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 1024;
`endif

   logic          clk;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [IW-1:0] insn;
   logic [XL-1:0] in0, in1;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [XL-1:0] rsp_payload_output;
   logic          vec_insn_valid;
   logic          vec_insn_ready;
   logic [IW-1:0] vec_insn;
   logic [XL-1:0] vec_data_in_1, vec_data_in_2;
   logic          vec_result_valid;
   logic [XL-1:0] vec_result;
   logic          err_timeout;

   vfu_cmd_bridge #(
      .INSN_WIDTH(IW), .XLEN(XL), .RSP_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk                    (clk),
      .reset                  (reset),
      .cmd_valid              (cmd_valid),
      .cmd_ready              (cmd_ready),
      .cmd_payload_instruction(insn),
      .cmd_payload_inputs_0   (in0),
      .cmd_payload_inputs_1   (in1),
      .rsp_valid              (rsp_valid),
      .rsp_ready              (rsp_ready),
      .rsp_payload_output     (rsp_payload_output),
      .vec_insn_valid         (vec_insn_valid),
      .vec_insn_ready         (vec_insn_ready),
      .vec_insn               (vec_insn),
      .vec_data_in_1          (vec_data_in_1),
      .vec_data_in_2          (vec_data_in_2),
      .vec_result_valid       (vec_result_valid),
      .vec_result             (vec_result),
      .err_timeout            (err_timeout)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL global_watchdog: time limit reached, got no finish, required finish");
      $fatal(1);
   end

   // ---------------- scoreboard ----------------
   int            errors = 0;
   int            checks = 0;
   logic [XL-1:0] exp_q[$];

   typedef struct {
      logic          needs;
      logic          done;
      logic [XL-1:0] data;
   } ent_t;
   ent_t mq[$];

   typedef struct {
      logic [IW-1:0] insn;
      logic          cv;
      logic          vr;
      logic          exp_cr;
      logic          exp_vv;
      logic          exp_imm;
   } vec_t;
   vec_t tbl[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset            = 1'b1;
      cmd_valid        = 1'b0;
      vec_result_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      mq.delete();
   endtask

   function automatic logic [31:0] mk_insn(input logic [5:0] f6, input logic [2:0] f3,
                                           input logic [6:0] opc, input logic [4:0] rd,
                                           input logic [4:0] vs2);
      return {f6, 1'b1, vs2, 5'd0, f3, rd, opc};
   endfunction

   logic [31:0] vmv_i, vadd_i;

   task automatic send(input logic [31:0] i_w, input logic [31:0] a, input logic [31:0] b);
      bit ok;
      ok        = 1'b0;
      cmd_valid = 1'b1;
      insn      = i_w;
      in0       = a;
      in1       = b;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         if (cmd_ready) ok = 1'b1;
         tick();
      end
      cmd_valid = 1'b0;
      check("send_accept", {31'd0, ok}, 32'd1);
   endtask

   task automatic get_rsp(input int budget, input string name);
      bit          got;
      logic [31:0] e;
      got = 1'b0;
      for (int k = 0; k < budget && !got; k++) begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) begin
            got = 1'b1;
            e   = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            check(name, rsp_payload_output, e);
         end
         tick();
      end
      check({name, "_arrived"}, {31'd0, got}, 32'd1);
   endtask

   task automatic pulse_result(input logic [31:0] r);
      vec_result_valid = 1'b1;
      vec_result       = r;
      tick();
      vec_result_valid = 1'b0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [31:0] r;
      logic        is_vmv, pending, exp_cr, exp_vv, exp_rv, acc, pop, found;
      logic [31:0] exp_pay;
      ent_t        e;

      vmv_i  = mk_insn(6'b010000, 3'b010, 7'b1010111, 5'd3, 5'd8);
      vadd_i = mk_insn(6'b000000, 3'b000, 7'b1010111, 5'd1, 5'd2);

      reset = 1'b1; cmd_valid = 1'b0; insn = '0; in0 = '0; in1 = '0;
      rsp_ready = 1'b0; vec_insn_ready = 1'b1; vec_result_valid = 1'b0; vec_result = '0;
      do_reset();
      rsp_ready = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_payload", rsp_payload_output, 32'd0);
      check("rst_err_timeout", err_timeout, 1'b0);
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_vec_valid", vec_insn_valid, 1'b0);
      tick();

      // T1: vadd.vv gives a zero response one cycle after accept
      cmd_valid = 1'b1; insn = vadd_i; in0 = 32'h1111_0001; in1 = 32'h2222_0002;
      @(negedge clk);
      check("t1_vec_valid", vec_insn_valid, 1'b1);
      check("t1_vec_insn", vec_insn, vadd_i);
      check("t1_data1", vec_data_in_1, 32'h1111_0001);
      check("t1_data2", vec_data_in_2, 32'h2222_0002);
      check("t1_cmd_ready", cmd_ready, 1'b1);
      tick();
      cmd_valid = 1'b0;
      exp_q.push_back(32'd0);
      get_rsp(1, "t1_rsp");
      @(negedge clk);
      check("t1_single_rsp", rsp_valid, 1'b0);
      check("t1_vec_idle", vec_insn_valid, 1'b0);
      tick();

      // T2: vmv.x.s, result arrives 5 cycles later
      send(vmv_i, 32'h5, 32'h6);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t2_wait", rsp_valid, 1'b0);
         tick();
      end
      vec_result_valid = 1'b1; vec_result = 32'h1234_5678;
      @(negedge clk);
      check("t2_not_yet", rsp_valid, 1'b0);
      tick();
      vec_result_valid = 1'b0;
      exp_q.push_back(32'h1234_5678);
      get_rsp(1, "t2_rsp");

      // T3: ordering vmv / vadd / vmv
      exp_q.push_back(32'hA); exp_q.push_back(32'h0); exp_q.push_back(32'hB);
      send(vmv_i, 0, 0);
      send(vadd_i, 0, 0);
      send(vmv_i, 0, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("t3_hold_order", rsp_valid, 1'b0);
         tick();
      end
      pulse_result(32'hA);
      get_rsp(1, "t3_a");
      get_rsp(1, "t3_vadd");
      @(negedge clk);
      check("t3_wait_b", rsp_valid, 1'b0);
      tick();
      pulse_result(32'hB);
      get_rsp(1, "t3_b");

      // T4: backpressure until the queue is full, then drain
      rsp_ready = 1'b0;
      for (int k = 0; k < DEPTH; k++) send(vadd_i, k, k);
      cmd_valid = 1'b1; insn = vadd_i;
      @(negedge clk);
      check("t4_full_cmd_ready", cmd_ready, 1'b0);
      check("t4_full_vec_valid", vec_insn_valid, 1'b0);
      check("t4_rsp_valid", rsp_valid, 1'b1);
      tick();
      cmd_valid = 1'b0;
      @(negedge clk);
      check("t4_hold_valid", rsp_valid, 1'b1);
      check("t4_hold_payload", rsp_payload_output, 32'd0);
      tick();
      rsp_ready = 1'b1;
      @(negedge clk);
      check("t4_full_pop_no_bypass", cmd_ready, 1'b0);
      check("t4_rsp0", rsp_valid, 1'b1);
      check("t4_rsp0_payload", rsp_payload_output, 32'd0);
      tick();
      for (int k = 1; k < DEPTH; k++) begin
         exp_q.push_back(32'd0);
         get_rsp(1, $sformatf("t4_rsp%0d", k));
      end
      @(negedge clk);
      check("t4_drained", rsp_valid, 1'b0);
      check("t4_cmd_ready_back", cmd_ready, 1'b1);
      tick();

      // T5: vec_insn_ready low blocks accept; reset flushes the queue
      vec_insn_ready = 1'b0; cmd_valid = 1'b1; insn = vadd_i;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("t5_cmd_ready_low", cmd_ready, 1'b0);
         check("t5_vec_valid_indep", vec_insn_valid, 1'b1);
         tick();
      end
      cmd_valid = 1'b0; vec_insn_ready = 1'b1;
      @(negedge clk);
      check("t5_no_growth", rsp_valid, 1'b0);
      tick();
      rsp_ready = 1'b0;
      send(vadd_i, 1, 1);
      send(vadd_i, 2, 2);
      @(negedge clk);
      check("t5_queued", rsp_valid, 1'b1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("t5_rst_rsp_valid", rsp_valid, 1'b0);
      check("t5_rst_payload", rsp_payload_output, 32'd0);
      check("t5_rst_cmd_ready", cmd_ready, 1'b1);
      tick();
      rsp_ready = 1'b1;
      @(negedge clk);
      check("t5_empty", rsp_valid, 1'b0);
      tick();
      send(vadd_i, 3, 3);
      exp_q.push_back(32'd0);
      get_rsp(1, "t5_fresh_rsp");
      @(negedge clk);
      check("t5_no_stale", rsp_valid, 1'b0);
      tick();

      // Table: handshake and decode vectors on an empty queue
      tbl[0] = '{vadd_i, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[1] = '{vmv_i,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[2] = '{mk_insn(6'b010000, 3'b000, 7'b1010111, 5'd4, 5'd5), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[3] = '{mk_insn(6'b010000, 3'b110, 7'b1010111, 5'd4, 5'd5), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[4] = '{mk_insn(6'b010000, 3'b010, 7'b0001011, 5'd4, 5'd5), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[5] = '{mk_insn(6'b010001, 3'b010, 7'b1010111, 5'd4, 5'd5), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[6] = '{vmv_i,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[7] = '{vadd_i, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[8] = '{mk_insn(6'b010000, 3'b010, 7'b1010111, 5'd31, 5'd17), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      rsp_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         cmd_valid = tbl[i].cv; vec_insn_ready = tbl[i].vr; insn = tbl[i].insn;
         in0 = $urandom; in1 = $urandom;
         @(negedge clk);
         check($sformatf("tbl%0d_cmd_ready", i), cmd_ready, tbl[i].exp_cr);
         check($sformatf("tbl%0d_vec_valid", i), vec_insn_valid, tbl[i].exp_vv);
         check($sformatf("tbl%0d_vec_insn", i), vec_insn, tbl[i].insn);
         check($sformatf("tbl%0d_data1", i), vec_data_in_1, in0);
         tick();
         cmd_valid = 1'b0; vec_insn_ready = 1'b1;
         if (tbl[i].cv && tbl[i].exp_cr) begin
            if (tbl[i].exp_imm) begin
               exp_q.push_back(32'd0);
               get_rsp(1, $sformatf("tbl%0d_imm", i));
            end else begin
               @(negedge clk);
               check($sformatf("tbl%0d_waits", i), rsp_valid, 1'b0);
               tick();
               r = $urandom;
               pulse_result(r);
               exp_q.push_back(r);
               get_rsp(1, $sformatf("tbl%0d_res", i));
            end
         end else begin
            @(negedge clk);
            check($sformatf("tbl%0d_no_accept", i), rsp_valid, 1'b0);
            tick();
         end
      end

      // Randomized run against the queue model
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         cmd_valid      = ($urandom_range(0, 9) < 6);
         is_vmv         = $urandom_range(0, 1);
         insn           = is_vmv ? mk_insn(6'b010000, 3'b010, 7'b1010111, 5'($urandom), 5'($urandom))
                                 : mk_insn(6'b000000, 3'b000, 7'b1010111, 5'($urandom), 5'($urandom));
         in0            = $urandom;
         in1            = $urandom;
         vec_insn_ready = ($urandom_range(0, 9) < 8);
         rsp_ready      = ($urandom_range(0, 9) < 6);
         pending = 1'b0;
         foreach (mq[j]) if (mq[j].needs && !mq[j].done) pending = 1'b1;
         vec_result_valid = pending ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
         vec_result       = $urandom;

         exp_cr  = vec_insn_ready && (mq.size() < DEPTH);
         exp_vv  = cmd_valid && (mq.size() < DEPTH);
         exp_rv  = (mq.size() > 0) && mq[0].done;
         exp_pay = (mq.size() > 0) ? mq[0].data : 32'd0;

         @(negedge clk);
         check("rnd_cmd_ready", cmd_ready, exp_cr);
         check("rnd_vec_valid", vec_insn_valid, exp_vv);
         check("rnd_rsp_valid", rsp_valid, exp_rv);
         check("rnd_err_timeout", err_timeout, 1'b0);
         if (exp_rv) check("rnd_rsp_payload", rsp_payload_output, exp_pay);
         if (cmd_valid) check("rnd_vec_insn", vec_insn, insn);
         tick();

         acc = cmd_valid && exp_cr;
         pop = exp_rv && rsp_ready;
         if (vec_result_valid) begin
            found = 1'b0;
            for (int j = 0; j < mq.size(); j++) begin
               if (!found && mq[j].needs && !mq[j].done) begin
                  e = mq[j]; e.done = 1'b1; e.data = vec_result; mq[j] = e;
                  found = 1'b1;
               end
            end
         end
         if (pop) void'(mq.pop_front());
         if (acc) begin
            e.needs = is_vmv; e.done = !is_vmv; e.data = '0;
            mq.push_back(e);
         end
      end
      cmd_valid = 1'b0; vec_result_valid = 1'b0; vec_insn_ready = 1'b1; rsp_ready = 1'b1;

`ifdef VFU_TIMEOUT_EN
      // Watchdog: vmv.x.s with no result
      do_reset();
      send(vmv_i, 0, 0);
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         check("to_wait", rsp_valid, 1'b0);
         check("to_err_low", err_timeout, 1'b0);
         tick();
      end
      exp_q.push_back(32'hDEAD_BEEF);
      get_rsp(6, "to_rsp");
      @(negedge clk);
      check("to_err_set", err_timeout, 1'b1);
      tick();
      repeat (3) tick();
      @(negedge clk);
      check("to_err_sticky", err_timeout, 1'b1);
      tick();
      do_reset();
      @(negedge clk);
      check("to_err_cleared", err_timeout, 1'b0);
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vfu_cmd_bridge.md
Name: vfu_cmd_bridge

Overview:
- Parametrised CFU-to-vector-core bridge that replaces the fixed two-stage valid shift with a real in-order response queue.
- Accepts CFU commands with valid/ready and forwards the instruction and both scalar operands to the vector core issue port.
- Returns exactly one CFU response per accepted command, in order, with full rsp_ready backpressure.
- Scalar-result instructions (vmv.x.s) wait for the core's result; all others get an immediate zero response.

Parameters:
- INSN_WIDTH, 32, instruction width.
- XLEN, 32, scalar operand and response width.
- RSP_DEPTH, 4, response-queue entries (power of 2, >=2); this is the maximum number of outstanding commands.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with VFU_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  CFU command valid
- cmd_ready  out  1  CFU command ready
- cmd_payload_instruction  in  INSN_WIDTH  instruction
- cmd_payload_inputs_0  in  XLEN  rs1 value
- cmd_payload_inputs_1  in  XLEN  rs2 value
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response ready
- rsp_payload_output  out  XLEN  response data
- vec_insn_valid  out  1  issue valid to vector core
- vec_insn_ready  in  1  vector core can issue
- vec_insn  out  INSN_WIDTH  forwarded instruction
- vec_data_in_1  out  XLEN  forwarded rs1
- vec_data_in_2  out  XLEN  forwarded rs2
- vec_result_valid  in  1  core scalar result strobe, one cycle per result
- vec_result  in  XLEN  core scalar result
- err_timeout  out  1  sticky watchdog error

Behaviour:
- Single clock. Reset is synchronous and active-high, sampled on posedge clk.
- During reset:
  - Queue is emptied; head, tail and fill pointers go to 0.
  - rsp_valid=0, rsp_payload_output=0, err_timeout=0.
  - Any in-flight state is discarded.
- Issue path and acceptance:
  - full = (count==RSP_DEPTH).
  - vec_insn_valid = cmd_valid & ~full. This is combinational and must not depend on vec_insn_ready.
  - cmd_ready = vec_insn_ready & ~full.
  - accept = cmd_valid & cmd_ready.
  - vec_insn, vec_data_in_1 and vec_data_in_2 are direct pass-throughs of the cmd payloads.
- Decode: needs_result = (insn[6:0]==7'b1010111) & (insn[14:12]==3'b010) & (insn[31:26]==6'b010000).
- Queue entry = {needs_result, done, data[XLEN-1:0]}.
  - On accept, write at tail.
  - If !needs_result: done=1, data=0.
  - Otherwise: done=0.
- Result fill:
  - A fill pointer tracks the oldest entry with needs_result & !done; the core returns results in issue order.
  - On vec_result_valid, write data into that entry, set done, and advance the fill pointer to the next needs_result entry.
  - vec_result_valid with no pending entry is dropped.
  - vec_result_valid in the same cycle its own instruction is accepted is illegal; ignore it.
- Response:
  - rsp_valid and rsp_payload_output are registered from the head entry: rsp_valid=1 the cycle after head.done becomes 1.
  - A non-result command accepted into an empty queue at cycle N gives rsp_valid=1 at cycle N+1.
  - Pop on rsp_valid & rsp_ready; the next done head appears the following cycle. Back-to-back done entries stream one per cycle.
  - rsp_payload_output is held stable while rsp_valid & ~rsp_ready.
- Simultaneous events:
  - accept + pop in the same cycle: count unchanged.
  - When full, cmd_ready=0 even if a pop occurs this cycle (no bypass).
  - vec_result_valid + pop + accept in the same cycle are all honoured.
- Pointers wrap modulo RSP_DEPTH; count is a $clog2(RSP_DEPTH)+1-bit counter.

Optional Feature:
- Macro: VFU_TIMEOUT_EN.
- With VFU_TIMEOUT_EN:
  - A counter runs while the head entry is needs_result & !done, and clears on pop or on head change.
  - When the count reaches TIMEOUT_CYCLES, the head is force-completed with data=32'hDEAD_BEEF and err_timeout is set.
  - err_timeout stays set until reset.
  - A late vec_result for that entry is dropped; the fill pointer has already advanced.
- Without VFU_TIMEOUT_EN: no counter is built, err_timeout is tied to 0, and the head waits indefinitely.

Test Plan:
- Reset, then one vadd.vv (non-result), rsp_ready=1 -> vec_insn_valid pulses with the command; rsp_valid=1 with payload 0 exactly 1 cycle after accept.
- vmv.x.s accepted; vec_result=32'h1234_5678 arrives 5 cycles later -> rsp_valid rises the next cycle with payload 32'h1234_5678.
- Order check: issue vmv.x.s, vadd.vv, vmv.x.s; core returns 0xA then 0xB -> responses in order 0xA, 0, 0xB; the vadd response is not emitted before 0xA.
- Backpressure: rsp_ready=0, issue RSP_DEPTH (4) non-result commands -> cmd_ready=0 after the 4th; raise rsp_ready -> 4 zero responses on consecutive cycles, then cmd_ready=1.
- vec_insn_ready=0 with cmd_valid=1 -> no accept and no queue growth; reset asserted with 2 entries queued -> rsp_valid=0 the next cycle and the queue is empty.
- VFU_TIMEOUT_EN with TIMEOUT_CYCLES=16: vmv.x.s issued and no result -> after 16 cycles the response is 32'hDEAD_BEEF and err_timeout=1 until reset.
